// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers shared by the dual-clock FIFO.
// Both functions work on a 32-bit container. Any pointer up to 32 bits wide
// gives the right result, provided it is zero-extended on the way in and
// truncated on the way out.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit k of the binary value is the XOR of all Gray bits at k and above.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// sync_bus: plain multi-flop synchroniser for a Gray-coded pointer bus.
module sync_bus #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] chain_q [STAGES];

  // Shift the crossing value through STAGES flops in the destination clock.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/async_fifo_fwft.sv
// async_fifo_fwft: dual-clock FIFO built on Gray-coded pointers.
// It has registered full/empty flags, fill counts and programmable thresholds,
// and one-cycle overflow/underflow pulses. Reads run in standard or
// first-word-fall-through mode.
module async_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DW          = 24,
  parameter int AW          = 5,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int PF_THRESH   = (1 << AW) - 4,
  parameter int PE_THRESH   = 4
) (
  input  logic          rst_n,
  input  logic          clk_r,
  input  logic          clk_w,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          prog_full,
  output logic [AW:0]   wr_count,
  output logic          overflow,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          prog_empty,
  output logic [AW:0]   rd_count,
  output logic          underflow
);

  localparam int          PW    = AW + 1;
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] PF_T  = PW'(PF_THRESH);
  localparam logic [AW:0] PE_T  = PW'(PE_THRESH);

  logic [DW-1:0] mem_q [DEPTH];

  // Write-domain state
  logic [AW:0] wbin_q, wbin_d, wgray_q, wgray_d, wr_count_q, wr_count_d;
  logic [AW:0] rsync, rsync_bin;
  logic        full_q, full_d, prog_full_q, overflow_q, wr_acc;

  // Read-domain state
  logic [AW:0] rbin_q, rbin_d, rgray_q, rgray_d, rd_count_q, rd_count_d;
  logic [AW:0] wsync, wsync_bin;
  logic        ram_empty_q, ram_empty_d, ram_rd;
  logic        dout_valid_q, dout_valid_d, underflow_q, underflow_d, prog_empty_q;
  logic [DW-1:0] dout_q;

  sync_bus #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk_i(clk_r), .rst_n(rst_n), .d_i(wgray_q), .q_o(wsync)
  );

  sync_bus #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk_i(clk_w), .rst_n(rst_n), .d_i(rgray_q), .q_o(rsync)
  );

  // Next write pointer, and flags computed from it, so full is never late.
  always_comb begin
    wr_acc     = wr_en && !full_q;
    wbin_d     = wbin_q + PW'(wr_acc);
    wgray_d    = PW'(bin2gray(32'(wbin_d)));
    rsync_bin  = PW'(gray2bin(32'(rsync)));
    wr_count_d = wbin_d - rsync_bin;
    full_d     = (wgray_d == {~rsync[AW:AW-1], rsync[AW-2:0]});
  end

  // Write-domain registers: pointers, flags, count and overflow pulse.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      wr_count_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      full_q      <= full_d;
      prog_full_q <= (wr_count_d >= PF_T);
      wr_count_q  <= wr_count_d;
      overflow_q  <= wr_en && full_q;
    end
  end

  // Storage array: synchronous write port on the write clock.
  always_ff @(posedge clk_w) begin
    if (wr_acc) mem_q[wbin_q[AW-1:0]] <= din;
  end

  // Choose when the RAM is popped. FWFT prefetches whenever the output
  // register is free or is being consumed in this cycle.
  always_comb begin
    if (FWFT != 0) begin
      ram_rd       = (!dout_valid_q || rd_en) && !ram_empty_q;
      dout_valid_d = ram_rd || (dout_valid_q && !rd_en);
      underflow_d  = rd_en && !dout_valid_q;
    end else begin
      ram_rd       = rd_en && !ram_empty_q;
      dout_valid_d = ram_rd;
      underflow_d  = rd_en && ram_empty_q;
    end
    rbin_d      = rbin_q + PW'(ram_rd);
    rgray_d     = PW'(bin2gray(32'(rbin_d)));
    wsync_bin   = PW'(gray2bin(32'(wsync)));
    rd_count_d  = wsync_bin - rbin_d;
    ram_empty_d = (rgray_d == wsync);
  end

  // Read-domain registers: pointers, flags, count, output word and pulses.
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      ram_empty_q  <= 1'b1;
      prog_empty_q <= 1'b1;
      rd_count_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      ram_empty_q  <= ram_empty_d;
      prog_empty_q <= (rd_count_d <= PE_T);
      rd_count_q   <= rd_count_d;
      dout_valid_q <= dout_valid_d;
      underflow_q  <= underflow_d;
      if (ram_rd) dout_q <= mem_q[rbin_q[AW-1:0]];
    end
  end

  assign full       = full_q;
  assign prog_full  = prog_full_q;
  assign wr_count   = wr_count_q;
  assign overflow   = overflow_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign empty      = (FWFT != 0) ? !dout_valid_q : ram_empty_q;
  assign prog_empty = prog_empty_q;
  assign rd_count   = rd_count_q;
  assign underflow  = underflow_q;

endmodule
